uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART byte transmitter between two byte-stream requesters: e.g. requester 0 is the CPU UART data register, requester 1 is the receive-echo/debug path.
- Contains a round-robin or fixed-priority arbiter, a DEPTH-entry byte FIFO, and a sequencer.
- The sequencer drives the transmitter's tx_data/tx_en pair and tracks its tx_status idle flag.
- Sits between the peripheral bus logic and the UART sender, all in the sysclk domain.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64
ADDR_W, 3, log2(DEPTH)
ARB_MODE, 0, 0 = round-robin between requesters; 1 = fixed priority, req0 wins

Ports:
sysclk  input  1  system clock
reset  input  1  asynchronous, active-low reset
req0_data  input  8  byte from requester 0
req0_valid  input  1  requester 0 has a byte
req0_ready  output  1  requester 0 byte accepted this cycle when valid&ready
req1_data  input  8  byte from requester 1
req1_valid  input  1  requester 1 has a byte
req1_ready  output  1  requester 1 byte accepted this cycle when valid&ready
flush  input  1  synchronous FIFO clear
tx_data  output  8  byte to transmitter, registered
tx_en  output  1  one-sysclk start pulse to transmitter, registered
tx_status  input  1  transmitter idle flag: 1 = idle, 0 = sending
fifo_count  output  ADDR_W+1  current FIFO occupancy
tx_busy  output  1  high when state != IDLE or fifo_count != 0

Behaviour:
- Reset (reset=0, async) values:
  - tx_data=8'h00, tx_en=0, fifo_count=0, state=IDLE.
  - last_grant=1, so req0 wins the first contention.
  - req0_ready=0, req1_ready=0, tx_busy=0.
- Arbitration (combinational, same cycle):
  - No ready is asserted when FIFO full or flush=1.
  - Otherwise, if only one requester is valid, it gets ready.
  - If both are valid:
    - ARB_MODE=0: grant the requester not equal to last_grant.
    - ARB_MODE=1: grant req0.
  - At most one ready is high per cycle. A ready is never asserted without the matching valid.
  - last_grant updates on every accepted push.
- Push: on the sysclk edge where the granted valid&ready=1, write data at wr_ptr; wr_ptr wraps modulo DEPTH.
- Pop and push in the same cycle: count unchanged.
- Full: count==DEPTH. Empty: count==0.
- flush=1: at the next edge, rd_ptr=wr_ptr=0 and count=0. flush does not abort a byte already loaded into tx_data.
- Sequencer states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if count!=0 and tx_status=1 and flush=0, then pop the head into tx_data and go to ISSUE. Otherwise stay.
  - ISSUE: tx_en=1 for exactly this one cycle; go to WAIT_BUSY.
  - WAIT_BUSY: stay until tx_status=0, then go to WAIT_DONE.
  - WAIT_DONE: stay until tx_status=1, then go to IDLE.
- tx_data is held stable from the load in IDLE until the next load. The transmitter samples tx_data throughout the frame on its baud clock, so tx_data must not change while it sends.
- Latency:
  - Push at edge N into an empty FIFO with the transmitter idle: tx_data is loaded at edge N+1 and tx_en is high in the cycle after edge N+2.
  - Back-to-back bytes: the next load occurs on the first IDLE cycle after tx_status returns to 1.
- tx_en is never asserted while tx_status=0.
- Reset asserted mid-frame:
  - All state clears immediately; no tx_en is pulsed.
  - The transmitter shares the same reset and returns idle.
- Requester data is accepted in arrival order per requester. Global order follows grant order.

Test Plan:
- Single byte: reset; req0 pushes 8'hA5 at edge N with tx_status=1 -> tx_data=8'hA5 after edge N+1, single tx_en pulse after edge N+2. Model tx_status low for 160 cycles -> no further tx_en; tx_busy falls after tx_status returns to 1.
- Contention, ARB_MODE=0: req0 and req1 both valid continuously with 0x10.. and 0x20.. respectively -> FIFO/tx order 0x10,0x20,0x11,0x21,…; readies never high together.
- Fixed priority, ARB_MODE=1: both valid -> only req0 accepted until req0_valid drops. req1 is then accepted the next cycle.
- Full FIFO: hold tx_status=0, push 8 bytes -> fifo_count=8, both readies 0. A ninth valid is held, not dropped. Releasing tx_status pops 8 bytes in order, each with one tx_en.
- Simultaneous push/pop with count=3 -> count stays 3. flush with count=5 while in WAIT_DONE -> count=0 next cycle, current tx_data unchanged, no extra tx_en.
- Async reset during WAIT_DONE -> tx_en=0, tx_data=0, count=0, state IDLE without a clock edge. After release, a new push transmits normally.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Shares one UART byte transmitter between two byte-stream requesters:
// an arbiter feeds a byte FIFO, and a sequencer issues one frame at a time.
module uart_tx_arbiter #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int ARB_MODE = 0
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [7:0]        req0_data,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [7:0]        req1_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              flush,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic              tx_status,
  output logic [ADDR_W:0]   fifo_count,
  output logic              tx_busy
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_en_q, tx_en_d;
  logic [7:0]        mem_q [DEPTH];

  logic       accept_ok;
  logic       pick0;
  logic       grant0;
  logic       grant1;
  logic       push;
  logic       pop;
  logic [7:0] push_data;

  // last_grant_q=1 means req1 was served last, so req0 wins the next tie.
  always_comb begin
    accept_ok    = reset && (count_q != FULL_CNT) && !flush;
    pick0        = (ARB_MODE != 0) || last_grant_q;
    grant0       = accept_ok && req0_valid && (!req1_valid || pick0);
    grant1       = accept_ok && req1_valid && (!req0_valid || !pick0);
    push         = grant0 || grant1;
    push_data    = grant0 ? req0_data : req1_data;
    last_grant_d = push ? grant1 : last_grant_q;
    pop          = (state_q == IDLE) && (count_q != '0) && tx_status && !flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // tx_data is only rewritten on a pop, so it stays put for the whole frame.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_en_d   = (state_q == ISSUE);
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_data_d = mem_q[rd_ptr_q];
          state_d   = ISSUE;
        end
      end
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (!tx_status) state_d = WAIT_DONE;
      WAIT_DONE: if (tx_status)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      tx_data_q    <= 8'h00;
      tx_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
      tx_en_q      <= tx_en_d;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign tx_data    = tx_data_q;
  assign tx_en      = tx_en_q;
  assign fifo_count = count_q;
  assign tx_busy    = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: round-robin instance with a behavioural transmitter,
// plus a fixed-priority instance whose transmitter never reports busy.
module tb_uart_tx_arbiter;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              sysclk = 1'b0;
  logic              reset  = 1'b1;
  logic [7:0]        req0_data = 8'h00, req1_data = 8'h00;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              flush = 1'b0;
  logic              req0_ready, req1_ready;
  logic [7:0]        tx_data;
  logic              tx_en;
  logic              tx_status;
  logic [ADDR_W:0]   fifo_count;
  logic              tx_busy;

  logic [7:0]        b0_data = 8'h00, b1_data = 8'h00;
  logic              b0_valid = 1'b0, b1_valid = 1'b0;
  logic              b0_ready, b1_ready;
  logic [7:0]        b_tx_data;
  logic              b_tx_en;
  logic              b_status = 1'b1;
  logic [ADDR_W:0]   b_count;
  logic              b_busy;

  uart_tx_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ARB_MODE(0)) dut (
    .sysclk(sysclk), .reset(reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .flush(flush), .tx_data(tx_data), .tx_en(tx_en), .tx_status(tx_status),
    .fifo_count(fifo_count), .tx_busy(tx_busy)
  );

  uart_tx_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .ARB_MODE(1)) dut_fp (
    .sysclk(sysclk), .reset(reset),
    .req0_data(b0_data), .req0_valid(b0_valid), .req0_ready(b0_ready),
    .req1_data(b1_data), .req1_valid(b1_valid), .req1_ready(b1_ready),
    .flush(flush), .tx_data(b_tx_data), .tx_en(b_tx_en), .tx_status(b_status),
    .fifo_count(b_count), .tx_busy(b_busy)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural transmitter: goes busy for a frame after seeing a start pulse.
  int busy_cnt    = 0;
  int frame_len   = 4;
  bit rand_frames = 1'b0;
  bit hold_low    = 1'b0;

  always @(posedge sysclk or negedge reset) begin
    if (!reset)             busy_cnt <= 0;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    else if (tx_en)         busy_cnt <= rand_frames ? int'($urandom_range(1, 6)) : frame_len;
  end
  assign tx_status = !hold_low && (busy_cnt == 0);

  int         en_cnt = 0;
  logic [7:0] en_log[$];

  always @(negedge sysclk) begin
    if (tx_en) begin
      en_cnt++;
      en_log.push_back(tx_data);
      check("tx_en_while_tx_idle", tx_status, 1);
    end
  end

  typedef struct {
    logic v0, v1, fl;
    logic e0, e1;
    logic be0, be1;
  } vec_t;
  vec_t vt[6];

  logic [7:0] exp_cont[8] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};

  int cyc, base, got, n0, n1, a0, a1;
  bit can, p0, e0, e1, st;
  logic [7:0] mq[$];
  bit   m_last, m_free, m_seen_low;
  int   m_k;
  logic [7:0] m_txd;

  task automatic do_reset();
    @(negedge sysclk);
    reset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; b0_valid = 1'b0; b1_valid = 1'b0;
    flush = 1'b0; hold_low = 1'b0; rand_frames = 1'b0;
    repeat (2) @(negedge sysclk);
    reset = 1'b1;
  endtask

  task automatic push0(input logic [7:0] d);
    @(negedge sysclk);
    req0_data = d; req0_valid = 1'b1;
    #1;
    check("push0_ready", req0_ready, 1);
    @(posedge sysclk); #1;
    req0_valid = 1'b0;
  endtask

  task automatic wait_busy_low(input int limit, output int waited);
    waited = 0;
    while (tx_busy && waited < limit) begin @(posedge sysclk); #1; waited++; end
    check("tx_busy_fell", tx_busy, 0);
  endtask

  task automatic wait_log(input int n, input int limit);
    int c = 0;
    while (en_log.size() < n && c < limit) begin @(posedge sysclk); #1; c++; end
    check("frames_sent", en_log.size(), n);
  endtask

  task automatic wait_status_low(input int limit);
    int c = 0;
    while (tx_status && c < limit) begin @(posedge sysclk); #1; c++; end
    check("tx_status_went_low", tx_status, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset values, with requests pending during reset
    #1;
    reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; b0_valid = 1'b1; b1_valid = 1'b1;
    #1;
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    check("rst_fp_req0_ready", b0_ready, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_fifo_count", fifo_count, 0);
    check("rst_tx_busy", tx_busy, 0);
    do_reset();

    // Combinational arbitration table, no clock edge consumed
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclk);
      req0_valid = vt[i].v0; req1_valid = vt[i].v1;
      b0_valid = vt[i].v0; b1_valid = vt[i].v1; flush = vt[i].fl;
      #1;
      check($sformatf("vec%0d_rr_req0_ready", i), req0_ready, vt[i].e0);
      check($sformatf("vec%0d_rr_req1_ready", i), req1_ready, vt[i].e1);
      check($sformatf("vec%0d_fp_req0_ready", i), b0_ready, vt[i].be0);
      check($sformatf("vec%0d_fp_req1_ready", i), b1_ready, vt[i].be1);
      req0_valid = 1'b0; req1_valid = 1'b0; b0_valid = 1'b0; b1_valid = 1'b0; flush = 1'b0;
    end

    // After a req0 push, round-robin favours req1 while fixed priority keeps req0
    @(negedge sysclk);
    req0_data = 8'h5A; req0_valid = 1'b1; b0_data = 8'h5A; b0_valid = 1'b1;
    @(posedge sysclk); #1;
    req0_valid = 1'b0; b0_valid = 1'b0;
    @(negedge sysclk);
    req0_valid = 1'b1; req1_valid = 1'b1; b0_valid = 1'b1; b1_valid = 1'b1;
    #1;
    check("rr_after_req0_req1_ready", req1_ready, 1);
    check("rr_after_req0_req0_ready", req0_ready, 0);
    check("fp_after_req0_req0_ready", b0_ready, 1);
    check("fp_after_req0_req1_ready", b1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0; b0_valid = 1'b0; b1_valid = 1'b0;

    // Single byte with a long frame
    do_reset();
    frame_len = 160;
    base = en_cnt;
    @(negedge sysclk);
    req0_data = 8'hA5; req0_valid = 1'b1;
    #1;
    check("single_ready", req0_ready, 1);
    @(posedge sysclk); #1;
    req0_valid = 1'b0;
    check("single_count_after_push", fifo_count, 1);
    check("single_busy_after_push", tx_busy, 1);
    @(posedge sysclk); #1;
    check("single_tx_data_loaded", tx_data, 8'hA5);
    check("single_tx_en_early", tx_en, 0);
    @(posedge sysclk); #1;
    check("single_tx_en_pulse", tx_en, 1);
    @(posedge sysclk); #1;
    check("single_tx_en_one_cycle", tx_en, 0);
    wait_busy_low(400, cyc);
    check("single_busy_spans_frame", (cyc >= 160), 1);
    check("single_tx_en_count", en_cnt - base, 1);

    // Round-robin contention
    do_reset();
    frame_len = 2;
    base = en_log.size();
    n0 = 0; n1 = 0;
    for (int c = 0; c < 200 && (n0 < 4 || n1 < 4); c++) begin
      @(negedge sysclk);
      req0_valid = (n0 < 4); req1_valid = (n1 < 4);
      req0_data = 8'(8'h10 + n0); req1_data = 8'(8'h20 + n1);
      #1;
      check("cont_single_ready", req0_ready & req1_ready, 0);
      a0 = int'(req0_valid & req0_ready);
      a1 = int'(req1_valid & req1_ready);
      @(posedge sysclk);
      n0 += a0; n1 += a1;
    end
    @(negedge sysclk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_log(base + 8, 500);
    for (int i = 0; i < 8; i++)
      if (base + i < en_log.size())
        check($sformatf("cont_order%0d", i), en_log[base + i], exp_cont[i]);

    // Fixed priority: req1 waits until req0 drops
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      b0_valid = 1'b1; b1_valid = 1'b1;
      b0_data = 8'(8'h40 + i); b1_data = 8'h60;
      #1;
      check($sformatf("fp_req0_wins%0d", i), b0_ready, 1);
      check($sformatf("fp_req1_held%0d", i), b1_ready, 0);
    end
    @(negedge sysclk);
    b0_valid = 1'b0;
    #1;
    check("fp_req1_after_drop", b1_ready, 1);
    @(posedge sysclk); #1;
    b1_valid = 1'b0;
    check("fp_first_byte", b_tx_data, 8'h40);

    // Full FIFO with the transmitter held busy
    do_reset();
    hold_low = 1'b1;
    frame_len = 3;
    base = en_log.size();
    for (int i = 0; i < 8; i++) push0(8'(8'h30 + i));
    @(negedge sysclk);
    req0_data = 8'h38; req0_valid = 1'b1;
    req1_data = 8'hEE; req1_valid = 1'b1;
    #1;
    check("full_count", fifo_count, 8);
    check("full_req0_ready", req0_ready, 0);
    check("full_req1_ready", req1_ready, 0);
    repeat (3) @(posedge sysclk);
    #1;
    check("full_count_held", fifo_count, 8);
    @(negedge sysclk);
    req1_valid = 1'b0; hold_low = 1'b0;
    got = 0;
    for (int c = 0; c < 50 && got == 0; c++) begin
      @(negedge sysclk); #1;
      if (req0_ready) got = 1;
    end
    check("full_ninth_accepted", got, 1);
    @(posedge sysclk); #1;
    req0_valid = 1'b0;
    wait_log(base + 9, 1000);
    for (int i = 0; i < 9; i++)
      if (base + i < en_log.size())
        check($sformatf("full_order%0d", i), en_log[base + i], 8'(8'h30 + i));
    wait_busy_low(100, cyc);
    check("full_one_tx_en_per_byte", en_log.size() - base, 9);

    // Simultaneous push/pop, then flush during a frame
    do_reset();
    hold_low = 1'b1;
    frame_len = 30;
    push0(8'h50); push0(8'h51); push0(8'h52);
    @(negedge sysclk);
    req0_data = 8'h53; req0_valid = 1'b1; hold_low = 1'b0;
    #1;
    check("pp_pre_count", fifo_count, 3);
    check("pp_ready", req0_ready, 1);
    @(posedge sysclk); #1;
    req0_valid = 1'b0;
    check("pp_count_unchanged", fifo_count, 3);
    check("pp_tx_data", tx_data, 8'h50);
    push0(8'h54); push0(8'h55);
    wait_status_low(50);
    repeat (2) @(posedge sysclk);
    #1;
    check("flush_pre_count", fifo_count, 5);
    base = en_cnt;
    @(negedge sysclk);
    flush = 1'b1;
    @(posedge sysclk); #1;
    check("flush_count", fifo_count, 0);
    check("flush_tx_data_kept", tx_data, 8'h50);
    @(negedge sysclk);
    flush = 1'b0;
    wait_busy_low(200, cyc);
    repeat (3) @(posedge sysclk);
    #1;
    check("flush_no_extra_tx_en", en_cnt - base, 0);
    check("flush_tx_data_after", tx_data, 8'h50);

    // Asynchronous reset mid-frame
    do_reset();
    frame_len = 40;
    push0(8'h66);
    wait_status_low(50);
    push0(8'h67);
    repeat (2) @(posedge sysclk);
    #1;
    check("ar_pre_count", fifo_count, 1);
    @(negedge sysclk);
    #2;
    reset = 1'b0;
    #1;
    check("ar_tx_en", tx_en, 0);
    check("ar_tx_data", tx_data, 8'h00);
    check("ar_count", fifo_count, 0);
    check("ar_tx_busy", tx_busy, 0);
    @(negedge sysclk);
    reset = 1'b1;
    frame_len = 3;
    base = en_log.size();
    push0(8'h77);
    wait_log(base + 1, 100);
    if (en_log.size() > base) check("ar_resume_byte", en_log[base], 8'h77);

    // Randomized traffic against a queue-based reference
    do_reset();
    rand_frames = 1'b1;
    mq.delete();
    m_last = 1'b1; m_free = 1'b1; m_seen_low = 1'b0; m_k = 0; m_txd = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      @(negedge sysclk);
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 40);
      req0_data  = 8'($urandom);
      req1_data  = 8'($urandom);
      flush      = ($urandom_range(0, 99) < 2);
      #1;
      can = !flush && (mq.size() < DEPTH);
      p0  = m_last;
      e0  = can && req0_valid && (!req1_valid || p0);
      e1  = can && req1_valid && !e0;
      check("rnd_req0_ready", req0_ready, e0);
      check("rnd_req1_ready", req1_ready, e1);
      st = tx_status;
      // A byte is in flight from its load until the transmitter has gone busy and back.
      if (!m_free) begin
        if (m_k >= 1) begin
          if (!m_seen_low) begin
            if (!st) m_seen_low = 1'b1;
          end else if (st) begin
            m_free = 1'b1;
          end
        end
        m_k++;
      end else if (mq.size() != 0 && st && !flush) begin
        m_txd = mq.pop_front();
        m_free = 1'b0; m_k = 0; m_seen_low = 1'b0;
      end
      if (flush) mq.delete();
      if (e0) begin mq.push_back(req0_data); m_last = 1'b0; end
      else if (e1) begin mq.push_back(req1_data); m_last = 1'b1; end
      @(posedge sysclk); #1;
      check("rnd_tx_en", tx_en, (!m_free && m_k == 1));
      check("rnd_tx_data", tx_data, m_txd);
      check("rnd_fifo_count", fifo_count, mq.size());
      check("rnd_tx_busy", tx_busy, (!m_free || mq.size() != 0));
    end
    @(negedge sysclk);
    req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
